lts_averager: RTL and testbench

Averages the two back-to-back 64-sample long training symbols produced by the LTS extraction stage into one noise-reduced 64-sample symbol. It sits directly downstream of the LTS extractor and feeds the FFT/CSI computation stage. The first symbol is buffered, each sample of the second symbol is averaged with its buffered counterpart, and the result is streamed out with a single-register AXI-Stream output stage. Malformed frames are rejected and reported.

---
 rtl/csi_pkg.sv | 16 +
 rtl/lts_sample_buffer.sv | 28 ++
 rtl/lts_averager.sv | 189 ++++++++++++++++++
 tb/tb_lts_averager.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared types and constants for the CSI front-end (LTS extraction / averaging).
// No logic; pure declarations.
// Imported by lts_averager and its sub-modules.
package csi_pkg;

  // Samples per long training symbol.
  localparam int LTS_LEN = 64;

  // Averager control states.
  typedef enum logic [1:0] {
    FILL    = 2'd0,  // buffering the first symbol
    AVERAGE = 2'd1,  // averaging the second symbol against the buffer
    DISCARD = 2'd2   // dropping the overlong tail of a malformed frame
  } lts_state_e;

endpackage

// File: rtl/lts_sample_buffer.sv
// Sample store for the first LTS symbol: sync write, async (combinational) read.
// Latency: write visible on the read port the cycle after the write edge.
// No flow control; the caller guarantees write and read are never used in the same state.
module lts_sample_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk_in,
  input  logic                     wr_en_in,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_in,
  input  logic [WIDTH-1:0]         wr_data_in,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_in,
  output logic [WIDTH-1:0]         rd_data_out
);

  // No reset on the storage so it maps onto distributed RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one sample per accepted FILL beat.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem[wr_addr_in] <= wr_data_in;
    end
  end

  assign rd_data_out = mem[rd_addr_in];

endmodule

// File: rtl/lts_averager.sv
// Averages two back-to-back LTS symbols sample-by-sample into one 64-sample symbol.
// Latency: a second-symbol beat accepted at cycle k is on avg_axis_* at cycle k+1.
// Backpressure: single output register; input stalls in AVERAGE only while that register is full and not drained.
module lts_averager
  import csi_pkg::*;
#(
  parameter int N_SAMPLES = LTS_LEN,
  parameter int DATA_W    = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                lts_axis_tvalid,
  input  logic                lts_axis_tlast,
  input  logic [2*DATA_W-1:0] lts_axis_tdata,
  output logic                lts_axis_tready,
  output logic                avg_axis_tvalid,
  output logic                avg_axis_tlast,
  output logic [2*DATA_W-1:0] avg_axis_tdata,
  input  logic                avg_axis_tready,
  output logic                err_out
);

  localparam int IDX_W  = $clog2(2 * N_SAMPLES);
  localparam int ADDR_W = $clog2(N_SAMPLES);
  localparam int BEAT_W = 2 * DATA_W;

  localparam logic [IDX_W-1:0] IDX_FILL_END = IDX_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_BASE     = IDX_W'(N_SAMPLES);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(2 * N_SAMPLES - 1);

  lts_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                avg_vld_q, avg_vld_d;
  logic                avg_last_q, avg_last_d;
  logic [BEAT_W-1:0]   avg_dat_q, avg_dat_d;
  logic                err_q, err_d;

  logic                in_rdy;
  logic                accept;
  logic                load;
  logic                load_last;
  logic                buf_wr_en;
  logic [ADDR_W-1:0]   buf_wr_addr;
  logic [ADDR_W-1:0]   buf_rd_addr;
  logic [BEAT_W-1:0]   buf_rd_dat;

  logic signed [DATA_W-1:0] in_i, in_q, buf_i, buf_q;
  logic signed [DATA_W:0]   sum_i, sum_q;
  logic        [DATA_W-1:0] avg_i, avg_q;

  assign accept = lts_axis_tvalid && in_rdy;

  // First symbol goes straight into the buffer; second symbol reads its partner at idx-N.
  assign buf_wr_en   = accept && (state_q == FILL);
  assign buf_wr_addr = ADDR_W'(idx_q);
  assign buf_rd_addr = ADDR_W'(idx_q - IDX_BASE);

  lts_sample_buffer #(
    .DEPTH (N_SAMPLES),
    .WIDTH (BEAT_W)
  ) u_buf (
    .clk_in      (clk_in),
    .wr_en_in    (buf_wr_en),
    .wr_addr_in  (buf_wr_addr),
    .wr_data_in  (lts_axis_tdata),
    .rd_addr_in  (buf_rd_addr),
    .rd_data_out (buf_rd_dat)
  );

  // Sign-extend to DATA_W+1 so the sum cannot overflow; the floor shift brings it back in range.
  assign in_i  = lts_axis_tdata[BEAT_W-1:DATA_W];
  assign in_q  = lts_axis_tdata[DATA_W-1:0];
  assign buf_i = buf_rd_dat[BEAT_W-1:DATA_W];
  assign buf_q = buf_rd_dat[DATA_W-1:0];
  assign sum_i = {in_i[DATA_W-1], in_i} + {buf_i[DATA_W-1], buf_i};
  assign sum_q = {in_q[DATA_W-1], in_q} + {buf_q[DATA_W-1], buf_q};
  assign avg_i = DATA_W'(sum_i >>> 1);
  assign avg_q = DATA_W'(sum_q >>> 1);

  // Input ready: held low in reset, gated by the output register only while averaging.
  always_comb begin
    in_rdy = 1'b0;
    if (!rst_in) begin
      case (state_q)
        AVERAGE: in_rdy = !avg_vld_q || avg_axis_tready;
        default: in_rdy = 1'b1;
      endcase
    end
  end

  // Frame-tracking FSM: next state, index, error pulse and output-load strobe.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (lts_axis_tlast) begin
            // Frame ended before the first symbol was complete.
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_FILL_END) begin
              state_d = AVERAGE;
            end
          end
        end
      end
      AVERAGE: begin
        if (accept) begin
          load = 1'b1;
          if (idx_q == IDX_LAST) begin
            load_last = 1'b1;
            idx_d     = '0;
            if (lts_axis_tlast) begin
              state_d = FILL;
            end else begin
              // Frame runs past two symbols: finish this one, drop the rest.
              err_d   = 1'b1;
              state_d = DISCARD;
            end
          end else if (lts_axis_tlast) begin
            // Short second symbol: close the output symbol early.
            load_last = 1'b1;
            err_d     = 1'b1;
            idx_d     = '0;
            state_d   = FILL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DISCARD: begin
        if (accept && lts_axis_tlast) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Output register: reload on a new average, otherwise drop valid once drained.
  always_comb begin
    avg_vld_d  = avg_vld_q;
    avg_last_d = avg_last_q;
    avg_dat_d  = avg_dat_q;
    if (load) begin
      avg_vld_d  = 1'b1;
      avg_last_d = load_last;
      avg_dat_d  = {avg_i, avg_q};
    end else if (avg_axis_tready) begin
      avg_vld_d = 1'b0;
    end
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= FILL;
      idx_q      <= '0;
      avg_vld_q  <= 1'b0;
      avg_last_q <= 1'b0;
      avg_dat_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      avg_vld_q  <= avg_vld_d;
      avg_last_q <= avg_last_d;
      avg_dat_q  <= avg_dat_d;
      err_q      <= err_d;
    end
  end

  assign lts_axis_tready = in_rdy;
  assign avg_axis_tvalid = avg_vld_q;
  assign avg_axis_tlast  = avg_last_q;
  assign avg_axis_tdata  = avg_dat_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_lts_averager.sv
// Directed bench for lts_averager: expected beats are queued up front and
// matched against every output handshake; inputs driven and outputs sampled
// on the falling clock edge.
module tb_lts_averager;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        lts_axis_tvalid;
  logic        lts_axis_tlast;
  logic [31:0] lts_axis_tdata;
  logic        lts_axis_tready;
  logic        avg_axis_tvalid;
  logic        avg_axis_tlast;
  logic [31:0] avg_axis_tdata;
  logic        avg_axis_tready;
  logic        err_out;

  int n_chk = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  int hold_cnt = 0;
  int stall_cnt = 0;
  logic tog_en = 1'b0;
  int tog_cnt = 0;
  logic stalled = 1'b0;
  logic [32:0] prev_beat = '0;
  logic [32:0] exp_q[$];

  lts_averager dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .lts_axis_tvalid (lts_axis_tvalid),
    .lts_axis_tlast  (lts_axis_tlast),
    .lts_axis_tdata  (lts_axis_tdata),
    .lts_axis_tready (lts_axis_tready),
    .avg_axis_tvalid (avg_axis_tvalid),
    .avg_axis_tlast  (avg_axis_tlast),
    .avg_axis_tdata  (avg_axis_tdata),
    .avg_axis_tready (avg_axis_tready),
    .err_out         (err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Input stimulus. kind 0: (100,-100)/(300,-301); kind 1: full-scale; kind 2: ramps.
  function automatic logic [31:0] in_beat(input int kind, input int b);
    int i_v, q_v, j;
    j = b - 64;
    case (kind)
      0: begin
        i_v = (b < 64) ? 100 : 300;
        q_v = (b < 64) ? -100 : -301;
      end
      1: begin
        i_v = 32767;
        q_v = -32768;
      end
      default: begin
        i_v = (b < 64) ? (b * 37 - 1000) : (201 - j * 53);
        q_v = (b < 64) ? (500 - b * 11) : (j * 7 - 603);
      end
    endcase
    return {i_v[15:0], q_v[15:0]};
  endfunction

  // Hand-derived averages. kind 2: I sum = -16j-799 -> -8j-400, Q sum = -4j-103 -> -2j-52.
  function automatic logic [31:0] exp_beat(input int kind, input int j);
    int i_v, q_v;
    case (kind)
      0: begin i_v = 200;   q_v = -201;   end
      1: begin i_v = 32767; q_v = -32768; end
      default: begin
        i_v = -8 * j - 400;
        q_v = -2 * j - 52;
      end
    endcase
    return {i_v[15:0], q_v[15:0]};
  endfunction

  task automatic push_exp(input int kind, input int count, input int last_pos);
    for (int j = 0; j < count; j++) begin
      exp_q.push_back({(j == last_pos), exp_beat(kind, j)});
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int w;
    @(negedge clk_in);
    lts_axis_tvalid = 1'b1;
    lts_axis_tdata  = d;
    lts_axis_tlast  = l;
    w = 0;
    while (!lts_axis_tready && w < 100) begin
      @(negedge clk_in);
      w++;
      stall_cnt++;
    end
    if (w >= 100) check("in_ready_timeout", 64'(w), 64'd0);
  endtask

  task automatic send_frame(input int kind, input int n, input int last_pos);
    for (int b = 0; b < n; b++) begin
      send_beat(in_beat(kind, b), (b == last_pos));
    end
  endtask

  task automatic idle();
    @(negedge clk_in);
    lts_axis_tvalid = 1'b0;
    lts_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk_in);
      w++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk_in);
  endtask

  // Downstream ready pattern: one cycle on, two cycles off.
  always @(posedge clk_in) begin
    #2;
    if (tog_en) begin
      avg_axis_tready = (tog_cnt == 0);
      tog_cnt = (tog_cnt + 1) % 3;
    end
  end

  // Output monitor: match handshaken beats in order, check hold while stalled, count err pulses.
  always @(negedge clk_in) begin
    if (rst_in) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        hold_cnt++;
        check("stall_hold_vld", 64'(avg_axis_tvalid), 64'd1);
        check("stall_hold_dat", 64'({avg_axis_tlast, avg_axis_tdata}), 64'(prev_beat));
      end
      if (avg_axis_tvalid && avg_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          check("avg_beat", 64'({avg_axis_tlast, avg_axis_tdata}), 64'(exp_q.pop_front()));
        end
        rx_cnt++;
      end
      stalled   = avg_axis_tvalid && !avg_axis_tready;
      prev_beat = {avg_axis_tlast, avg_axis_tdata};
      if (err_out) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb;
    int rb;
    rst_in          = 1'b1;
    lts_axis_tvalid = 1'b0;
    lts_axis_tlast  = 1'b0;
    lts_axis_tdata  = '0;
    avg_axis_tready = 1'b1;

    // Reset state
    @(negedge clk_in);
    check("rst_tvalid", 64'(avg_axis_tvalid), 64'd0);
    check("rst_tlast",  64'(avg_axis_tlast),  64'd0);
    check("rst_tdata",  64'(avg_axis_tdata),  64'd0);
    check("rst_err",    64'(err_out),         64'd0);
    check("rst_tready", 64'(lts_axis_tready), 64'd0);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1 check("tready_after_rst", 64'(lts_axis_tready), 64'd1);

    // Two back-to-back frames, no bubbles, latency of one cycle
    eb = err_cnt;
    stall_cnt = 0;
    push_exp(0, 64, 63);
    push_exp(2, 64, 63);
    send_frame(0, 128, 127);
    send_frame(2, 128, 127);
    idle();
    check("lat_vld",  64'(avg_axis_tvalid), 64'd1);
    check("lat_last", 64'(avg_axis_tlast),  64'd1);
    check("lat_dat",  64'(avg_axis_tdata),  64'(exp_beat(2, 63)));
    @(negedge clk_in);
    check("vld_clear", 64'(avg_axis_tvalid), 64'd0);
    check("no_bubble", 64'(stall_cnt), 64'd0);
    drain("t1_drain");
    check("t1_no_err", 64'(err_cnt - eb), 64'd0);

    // Full-scale inputs must not wrap
    push_exp(1, 64, 63);
    send_frame(1, 128, 127);
    idle();
    drain("fullscale_drain");

    // Downstream backpressure 1 on / 2 off
    eb = err_cnt;
    hold_cnt = 0;
    tog_en = 1'b1;
    push_exp(2, 64, 63);
    send_frame(2, 128, 127);
    idle();
    drain("stall_drain");
    tog_en = 1'b0;
    @(negedge clk_in);
    avg_axis_tready = 1'b1;
    check("stalls_seen", 64'(hold_cnt > 0), 64'd1);
    check("stall_no_err", 64'(err_cnt - eb), 64'd0);
    repeat (2) @(negedge clk_in);

    // tlast on beat 50 (still filling): one err pulse, no output
    eb = err_cnt;
    send_frame(0, 51, 50);
    idle();
    check("fill_err_pulse", 64'(err_out), 64'd1);
    @(negedge clk_in);
    check("fill_err_once", 64'(err_out), 64'd0);
    push_exp(2, 64, 63);
    send_frame(2, 128, 127);
    idle();
    drain("after_fill_err");
    check("fill_err_cnt", 64'(err_cnt - eb), 64'd1);

    // tlast on beat 90 (averaging): 27 outputs, last one flagged
    eb = err_cnt;
    push_exp(0, 27, 26);
    send_frame(0, 91, 90);
    idle();
    drain("short_drain");
    check("short_err_cnt", 64'(err_cnt - eb), 64'd1);

    // 128 beats without tlast, 5 extra beats dropped
    eb = err_cnt;
    push_exp(0, 64, 63);
    send_frame(0, 128, -1);
    for (int k = 0; k < 5; k++) send_beat(32'h1234_5678, (k == 4));
    idle();
    drain("long_drain");
    check("long_err_cnt", 64'(err_cnt - eb), 64'd1);
    push_exp(2, 64, 63);
    send_frame(2, 128, 127);
    idle();
    drain("after_long");

    // Reset after 20 output beats
    rb = rx_cnt;
    push_exp(0, 64, 63);
    for (int b = 0; b < 84; b++) send_beat(in_beat(0, b), 1'b0);
    @(negedge clk_in);
    lts_axis_tvalid = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    check("midrst_tvalid", 64'(avg_axis_tvalid), 64'd0);
    check("midrst_tdata",  64'(avg_axis_tdata),  64'd0);
    check("midrst_tlast",  64'(avg_axis_tlast),  64'd0);
    check("midrst_tready", 64'(lts_axis_tready), 64'd0);
    check("midrst_rx",     64'(rx_cnt - rb),     64'd20);
    exp_q.delete();
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    push_exp(2, 64, 63);
    send_frame(2, 128, 127);
    idle();
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
